// File: rtl/useq_pkg.sv
// useq_pkg: shared types and microword layout for the microsequencer
package useq_pkg;
  localparam int UPC_W_DEF = 5;
  localparam int UOP_W_DEF = 12;
  localparam int TGT_LSB = UOP_W_DEF;
  localparam int SEL_LSB = TGT_LSB + UPC_W_DEF;
  localparam int POL_BIT = SEL_LSB + 3;
  localparam int OP_LSB = POL_BIT + 1;
  localparam int UWORD_W = OP_LSB + 3;
  typedef enum logic [2:0] {
    OP_NEXT, OP_JUMP, OP_CJUMP, OP_CALL, OP_RET, OP_WAIT, OP_DISPATCH, OP_HALT
  } useq_op_e;
  typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} useq_state_e;
  typedef struct packed {
    useq_op_e               op;
    logic                   pol;
    logic [2:0]             cond_sel;
    logic [UPC_W_DEF-1:0]   target;
    logic [UOP_W_DEF-1:0]   uop;
  } uword_t;
endpackage

// File: rtl/useq_stack.sv
// useq_stack: micro-subroutine return LIFO with occupancy flags
module useq_stack #(
  parameter int DEPTH = 4,
  parameter int W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] top_idx;
  assign top_idx = sp[AW-1:0] - AW'(1);
  assign top = mem[top_idx];
  assign full = sp == (AW+1)'(DEPTH);
  assign empty = sp == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[sp[AW-1:0]] <= din;
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end
endmodule

// File: rtl/useq_ctrl.sv
// useq_ctrl: decodes the current microword and steers the micro-PC
module useq_ctrl
  import useq_pkg::*;
#(
  parameter int UPC_W = UPC_W_DEF,
  parameter int UOP_W = UOP_W_DEF,
  parameter int STACK_DEPTH = 4,
  parameter int COND_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [UPC_W-1:0]   upc,
  input  logic [UOP_W+11:0]  uword,
  input  logic [COND_W-1:0]  cond,
  input  logic [UPC_W-1:0]   dispatch_addr,
  input  logic               start,
  output logic               load_incr,
  output logic [UPC_W-1:0]   upc_next,
  output logic [UOP_W-1:0]   uops,
  output logic               halted,
  output logic               fault
);
  uword_t w;
  useq_state_e state, state_n;
  logic c, push, pop, full, empty;
  logic [UPC_W-1:0] top;
  logic [$clog2(STACK_DEPTH):0] sp;
  logic unused_sp;
  assign w = uword;
  assign c = cond[w.cond_sel] ^ w.pol;
  assign unused_sp = ^sp;
  assign halted = state == S_HALT && !reset;
  assign fault = state == S_FAULT && !reset;
  useq_stack #(.DEPTH(STACK_DEPTH), .W(UPC_W)) u_stack (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(upc + 1'b1),
    .top(top), .sp(sp), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= S_RUN;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    load_incr = 1'b0;
    upc_next = upc;
    uops = w.uop;
    push = 1'b0;
    pop = 1'b0;
    if (reset) begin
      load_incr = 1'b1;
      upc_next = '0;
      uops = '0;
    end else if (state == S_HALT) begin
      load_incr = !start;
      uops = '0;
      state_n = start ? S_RUN : S_HALT;
    end else if (state == S_FAULT) begin
      load_incr = 1'b1;
      uops = '0;
    end else begin
      case (w.op)
        OP_NEXT: load_incr = 1'b0;
        OP_JUMP: begin
          load_incr = 1'b1;
          upc_next = w.target;
        end
        OP_CJUMP: begin
          load_incr = c;
          upc_next = w.target;
        end
        OP_CALL: begin
          load_incr = 1'b1;
          upc_next = full ? upc : w.target;
          uops = full ? '0 : w.uop;
          push = !full;
          state_n = full ? S_FAULT : S_RUN;
        end
        OP_RET: begin
          load_incr = 1'b1;
          upc_next = empty ? upc : top;
          uops = empty ? '0 : w.uop;
          pop = !empty;
          state_n = empty ? S_FAULT : S_RUN;
        end
        OP_WAIT: begin
          load_incr = !c;
          uops = c ? w.uop : '0;
        end
        OP_DISPATCH: begin
          load_incr = 1'b1;
          upc_next = dispatch_addr;
        end
        OP_HALT: begin
          load_incr = 1'b1;
          uops = '0;
          state_n = S_HALT;
        end
        default: load_incr = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_useq_ctrl.sv
// tb_useq_ctrl: directed vectors with a queue-based scoreboard
module tb_useq_ctrl;
  logic clk = 0, reset = 1, start = 0, load_incr, halted, fault;
  logic [4:0] upc = 0, dispatch_addr = 0, upc_next;
  logic [23:0] uword = 0;
  logic [7:0] cond = 0;
  logic [11:0] uops;
  int passed = 0, total = 0;
  typedef struct {
    string nm;
    logic li;
    logic [4:0] nx;
    logic nxc;
    logic [11:0] u;
    logic h;
    logic f;
  } exp_t;
  exp_t q[$];

  useq_ctrl dut (
    .clk(clk), .reset(reset), .upc(upc), .uword(uword), .cond(cond),
    .dispatch_addr(dispatch_addr), .start(start), .load_incr(load_incr),
    .upc_next(upc_next), .uops(uops), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (load_incr !== e.li || (e.nxc && upc_next !== e.nx) || uops !== e.u ||
          halted !== e.h || fault !== e.f)
        $display("FAIL %s: got li=%b nx=%0d uops=%h h=%b f=%b, want li=%b nx=%0d(care=%b) uops=%h h=%b f=%b",
                 e.nm, load_incr, upc_next, uops, halted, fault, e.li, e.nx, e.nxc, e.u, e.h, e.f);
      else passed++;
    end
  end

  task automatic cyc(input string nm, input logic [2:0] op, input logic p, input logic [2:0] cs,
                     input logic [4:0] tg, input logic [11:0] u, input logic [4:0] pc,
                     input logic [7:0] cd, input logic st, input logic eli, input logic [4:0] enx,
                     input logic enc, input logic [11:0] eu, input logic eh, input logic ef);
    exp_t e;
    uword = {op, p, cs, tg, u};
    upc = pc;
    cond = cd;
    start = st;
    e.nm = nm; e.li = eli; e.nx = enx; e.nxc = enc; e.u = eu; e.h = eh; e.f = ef;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc("rst_call", 3, 0, 0, 20, 12'hABC, 6, 0, 0, 1, 0, 1, 0, 0, 0);
    cyc("rst_hold", 7, 0, 0, 20, 12'hABC, 6, 0, 0, 1, 0, 1, 0, 0, 0);
    reset = 0;
    cyc("next", 0, 0, 0, 0, 12'h123, 3, 0, 0, 0, 0, 0, 12'h123, 0, 0);
    cyc("cj_taken", 2, 0, 2, 17, 12'h011, 4, 8'h04, 0, 1, 17, 1, 12'h011, 0, 0);
    cyc("cj_not", 2, 0, 2, 17, 12'h011, 4, 8'h00, 0, 0, 0, 0, 12'h011, 0, 0);
    cyc("cj_inv_not", 2, 1, 2, 17, 12'h011, 4, 8'h04, 0, 0, 0, 0, 12'h011, 0, 0);
    cyc("cj_inv_taken", 2, 1, 2, 17, 12'h011, 4, 8'hFB, 0, 1, 17, 1, 12'h011, 0, 0);
    cyc("call", 3, 0, 0, 20, 12'h055, 6, 0, 0, 1, 20, 1, 12'h055, 0, 0);
    cyc("ret", 4, 0, 0, 0, 12'h066, 21, 0, 0, 1, 7, 1, 12'h066, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("wait_hold", 5, 0, 5, 0, 12'h0AA, 10, 8'hDF, 0, 1, 10, 1, 0, 0, 0);
    cyc("wait_go", 5, 0, 5, 0, 12'h0AA, 10, 8'h20, 0, 0, 0, 0, 12'h0AA, 0, 0);
    dispatch_addr = 12;
    cyc("dispatch", 6, 0, 0, 0, 12'h0BB, 11, 0, 0, 1, 12, 1, 12'h0BB, 0, 0);
    cyc("halt", 7, 0, 0, 0, 12'h777, 31, 0, 0, 1, 31, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc("halted", 7, 0, 0, 0, 12'h777, 31, 0, 0, 1, 31, 1, 0, 1, 0);
    cyc("start", 7, 0, 0, 0, 12'h777, 31, 0, 1, 0, 0, 0, 0, 1, 0);
    cyc("resume", 0, 0, 0, 0, 12'h321, 0, 0, 0, 0, 0, 0, 12'h321, 0, 0);
    for (int i = 1; i <= 4; i++)
      cyc("call_nest", 3, 0, 0, 8, 12'h001, 5'(i), 0, 0, 1, 8, 1, 12'h001, 0, 0);
    cyc("ret_top", 4, 0, 0, 0, 12'h002, 8, 0, 0, 1, 5, 1, 12'h002, 0, 0);
    cyc("call_refill", 3, 0, 0, 8, 12'h001, 9, 0, 0, 1, 8, 1, 12'h001, 0, 0);
    cyc("call_ovf", 3, 0, 0, 8, 12'h001, 10, 0, 0, 1, 10, 1, 0, 0, 0);
    cyc("fault_start", 0, 0, 0, 0, 12'h001, 11, 0, 1, 1, 11, 1, 0, 0, 1);
    cyc("fault_hold", 1, 0, 0, 3, 12'h001, 11, 0, 0, 1, 11, 1, 0, 0, 1);
    reset = 1;
    cyc("rst_fault", 3, 0, 0, 8, 12'h001, 11, 0, 0, 1, 0, 1, 0, 0, 0);
    reset = 0;
    cyc("call_wrap", 3, 0, 0, 2, 12'h0CC, 31, 0, 0, 1, 2, 1, 12'h0CC, 0, 0);
    cyc("ret_wrap", 4, 0, 0, 0, 12'h0DD, 2, 0, 0, 1, 0, 1, 12'h0DD, 0, 0);
    cyc("ret_unf", 4, 0, 0, 0, 12'h0EE, 9, 0, 0, 1, 9, 1, 0, 0, 0);
    cyc("unf_fault", 0, 0, 0, 0, 12'h0EE, 9, 0, 0, 1, 9, 1, 0, 0, 1);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/useq_ctrl.md
Name: useq_ctrl

Overview:
Microsequencer control block: the driving end of the micro-program counter interface. Each cycle it decodes the microword fetched from the control store at the current upc. It then drives load_incr and upc_next back to the micro-PC register to select increment, branch, call/return, dispatch, wait or halt. It also gates the micro-op field out to the datapath and holds a small micro-subroutine return stack.

Parameters:
UPC_W, 5, micro-address width; must match the micro-PC register
UOP_W, 12, width of the micro-op control field passed to the datapath
STACK_DEPTH, 4, return-stack entries (power of two, 2..8)
COND_W, 8, number of condition inputs selectable by cond_sel (fixed 8, 3-bit select)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
upc  input  UPC_W  current micro-address from the micro-PC register
uword  input  UOP_W+12  microword read at upc (combinational control-store output)
cond  input  8  datapath status flags
dispatch_addr  input  UPC_W  opcode-mapped entry address
start  input  1  single-cycle pulse; resumes from HALT
load_incr  output  1  1 = micro-PC loads upc_next, 0 = micro-PC increments
upc_next  output  UPC_W  load value for the micro-PC
uops  output  UOP_W  gated micro-op field
halted  output  1  high in HALT state
fault  output  1  sticky stack over/underflow flag

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. All state updates happen on the rising edge of clk.
- Microword fields, MSB first: op[3], pol[1], cond_sel[3], target[UPC_W], uop[UOP_W].
- Condition: c = cond[cond_sel] XOR pol.
- State machine: RUN, HALT, FAULT. Reset enters RUN with sp=0, fault=0 and the stack contents cleared.
- Reset-cycle outputs (while reset=1): load_incr=1, upc_next=0, uops=0, halted=0, fault=0. This forces micro-address 0.
- Timing: outputs are combinational from state, uword, upc, cond and the stack top. They take effect at the micro-PC on the next edge, so each op has zero added latency. Stack and state update on the same edge.
- Op behaviour in RUN (uops = uop field unless stated otherwise):
  - NEXT (0): load_incr=0.
  - JUMP (1): load_incr=1, upc_next=target.
  - CJUMP (2): if c, load_incr=1 and upc_next=target; otherwise load_incr=0.
  - CALL (3): load_incr=1, upc_next=target. Push upc+1 (mod 2^UPC_W); sp++.
  - RET (4): load_incr=1, upc_next=stack[sp-1]; sp--.
  - WAIT (5): while c=0, load_incr=1, upc_next=upc (hold) and uops=0. When c=1, load_incr=0 and uops=uop.
  - DISPATCH (6): load_incr=1, upc_next=dispatch_addr.
  - HALT (7): load_incr=1, upc_next=upc, uops=0. Next state is HALT.
- HALT state:
  - Outputs: halted=1, uops=0.
  - start=0: load_incr=1, upc_next=upc (hold).
  - start=1: load_incr=0 (advance past the HALT word); next state is RUN.
  - start pulses seen in RUN or FAULT are ignored.
- Stack faults:
  - CALL with sp==STACK_DEPTH: no push; upc_next=upc (hold), uops=0. Next state is FAULT and fault sets.
  - RET with sp==0: same handling as CALL overflow.
- FAULT state: load_incr=1, upc_next=upc, uops=0, fault=1. Only reset exits this state.
- upc+1 wraps modulo 2^UPC_W; the wrap is not flagged.
- Reset asserted during any op, including a CALL in the same cycle, takes priority: no push occurs and the state returns to RUN.

Decomposition:
- Package useq_pkg: the op enum (useq_op_e, 3 bits), the state enum (useq_state_e), field-position localparams derived from UOP_W/UPC_W, and the struct uword_t.
- One sub-module, useq_stack: a LIFO with push, pop, top, sp, full and empty. It has the same clock and synchronous reset.

Test Plan:
- Reset, then NEXT at upc=3 -> load_incr=0, uops=uop field. Hold reset with any uword -> load_incr=1, upc_next=0, uops=0.
- CJUMP at upc=4, cond_sel=2, pol=0, target=17: cond[2]=1 -> load_incr=1, upc_next=17; cond[2]=0 -> load_incr=0. Repeat with pol=1 and confirm the outcome inverts.
- CALL target=20 at upc=6, then RET at upc=21 -> RET drives upc_next=7. Nest 4 CALLs (sp=4); a 5th CALL -> FAULT, fault=1, upc_next=upc, uops=0. State persists until reset.
- RET with sp=0 at upc=9 -> FAULT, upc_next=9, fault=1.
- WAIT at upc=10, cond_sel=5: hold cond[5]=0 for 3 cycles -> load_incr=1, upc_next=10, uops=0 each cycle. cond[5]=1 -> load_incr=0, uops=uop.
- HALT at upc=31 -> halted=1, upc_next=31 for 5 cycles. Pulse start -> load_incr=0 (upc wraps to 0), halted=0 the next cycle. DISPATCH with dispatch_addr=12 -> upc_next=12.
